// File: rtl/updown_count_controller_pkg.sv
// Shared state encoding, step direction codes and sizing helper for the
// up/down count controller and its repeat timer.
package updown_count_controller_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INC_HOLD = 3'd1,
        INC_REP  = 3'd2,
        DEC_HOLD = 3'd3,
        DEC_REP  = 3'd4,
        LOCK     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // Enough bits to hold the largest terminal count (longest interval - 1).
    function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
        int longest;
        longest = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        return (longest > 2) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/updown_count_controller_repeat_timer.sv
// Hold / auto-repeat interval timer: counts while run is high and pulses
// expire on the last cycle of the selected interval, then starts over.
module repeat_timer
    import updown_count_controller_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic restart,
    input  logic hold_select,
    output logic expire
);

    localparam int TIMER_W = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] last;

    assign last   = hold_select ? HOLD_LAST : REPEAT_LAST;
    assign expire = run && !restart && (timer == last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (restart || expire) begin
            timer <= '0;
        end else if (run) begin
            timer <= timer + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/updown_count_controller.sv
// Turns debounced increase/decrease button levels into a bounded up/down
// count with press arbitration, hold-to-auto-repeat and wrap/saturate limits.
module updown_count_controller
    import updown_count_controller_pkg::*;
#(
    parameter int WIDTH         = 7,
    parameter int MAX_VALUE     = 127,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int WRAP          = 1
) (
    input  logic             reset,
    input  logic             clock,
    input  logic             inc_level,
    input  logic             dec_level,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             step_inc,
    output logic             step_dec,
    output logic             at_max,
    output logic             at_min,
    output logic             active
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX_VALUE);

    state_t state;
    dir_t   step_dir;
    logic   inc_prev;
    logic   dec_prev;
    logic   inc_rise;
    logic   dec_rise;
    logic   owner_held;
    logic   hold_phase;
    logic   timer_restart;
    logic   timer_expire;

    function automatic logic [WIDTH-1:0] next_up(input logic [WIDTH-1:0] value);
        return (value == MAX_COUNT) ? '0 : value + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] next_down(input logic [WIDTH-1:0] value);
        return (value == '0) ? MAX_COUNT : value - WIDTH'(1);
    endfunction

    // In saturate mode a step at the limit is swallowed entirely (no pulse).
    function automatic logic can_move_up(input logic [WIDTH-1:0] value);
        return (WRAP != 0) || (value != MAX_COUNT);
    endfunction

    function automatic logic can_move_down(input logic [WIDTH-1:0] value);
        return (WRAP != 0) || (value != '0);
    endfunction

    assign inc_rise = inc_level && !inc_prev;
    assign dec_rise = dec_level && !dec_prev;

    always_comb begin
        owner_held = 1'b0;
        case (state)
            INC_HOLD, INC_REP: owner_held = inc_level;
            DEC_HOLD, DEC_REP: owner_held = dec_level;
            default:           owner_held = 1'b0;
        endcase
    end

    assign hold_phase    = (state == INC_HOLD) || (state == DEC_HOLD);
    assign timer_restart = clear || !owner_held;

    repeat_timer #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_repeat_timer (
        .clock       (clock),
        .reset       (reset),
        .run         (owner_held),
        .restart     (timer_restart),
        .hold_select (hold_phase),
        .expire      (timer_expire)
    );

    // A rise of the non-owning button while the owner is held never steps.
    always_comb begin
        step_dir = DIR_NONE;
        case (state)
            IDLE: begin
                if (inc_rise && !dec_rise) begin
                    step_dir = DIR_UP;
                end else if (dec_rise && !inc_rise) begin
                    step_dir = DIR_DOWN;
                end
            end
            INC_HOLD, INC_REP: if (timer_expire) step_dir = DIR_UP;
            DEC_HOLD, DEC_REP: if (timer_expire) step_dir = DIR_DOWN;
            default:           step_dir = DIR_NONE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            inc_prev <= 1'b0;
            dec_prev <= 1'b0;
            count    <= '0;
            step_inc <= 1'b0;
            step_dec <= 1'b0;
        end else begin
            inc_prev <= inc_level;
            dec_prev <= dec_level;
            step_inc <= 1'b0;
            step_dec <= 1'b0;
            if (clear) begin
                count <= '0;
                state <= (inc_level || dec_level) ? LOCK : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (inc_rise && dec_rise) begin
                            state <= LOCK;
                        end else if (inc_rise) begin
                            state <= INC_HOLD;
                        end else if (dec_rise) begin
                            state <= DEC_HOLD;
                        end
                    end
                    INC_HOLD, INC_REP: begin
                        if (!inc_level) begin
                            state <= dec_level ? LOCK : IDLE;
                        end else if (timer_expire) begin
                            state <= INC_REP;
                        end
                    end
                    DEC_HOLD, DEC_REP: begin
                        if (!dec_level) begin
                            state <= inc_level ? LOCK : IDLE;
                        end else if (timer_expire) begin
                            state <= DEC_REP;
                        end
                    end
                    LOCK: begin
                        if (!inc_level && !dec_level) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                case (step_dir)
                    DIR_UP: begin
                        if (can_move_up(count)) begin
                            count    <= next_up(count);
                            step_inc <= 1'b1;
                        end
                    end
                    DIR_DOWN: begin
                        if (can_move_down(count)) begin
                            count    <= next_down(count);
                            step_dec <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign at_max = (count == MAX_COUNT);
    assign at_min = (count == '0);
    assign active = (state != IDLE);

endmodule

// File: tb/tb_updown_count_controller.sv
// Bench for updown_count_controller: a wrap and a saturate instance share
// stimulus and are checked against a cycle-level behavioural model.
module tb_updown_count_controller;

    localparam int MAXV   = 9;
    localparam int HOLD   = 8;
    localparam int REPEAT = 4;
    localparam int M_IDLE = 0;
    localparam int M_INC  = 1;
    localparam int M_DEC  = 2;
    localparam int M_LOCK = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       inc_level;
    logic       dec_level;
    logic       clear;
    logic [3:0] count_w, count_s;
    logic       step_inc_w, step_dec_w, at_max_w, at_min_w, active_w;
    logic       step_inc_s, step_dec_s, at_max_s, at_min_s, active_s;

    int errors = 0;
    int checks = 0;

    // Model state: press mode, edges held since last step, repeat phase flag.
    int m_count[2];
    bit m_si[2];
    bit m_sd[2];
    int m_mode;
    int m_since;
    bit m_rep;
    bit m_pi;
    bit m_pd;

    updown_count_controller #(
        .WIDTH(4), .MAX_VALUE(MAXV), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .WRAP(1)
    ) dut_w (
        .reset(reset), .clock(clock), .inc_level(inc_level), .dec_level(dec_level),
        .clear(clear), .count(count_w), .step_inc(step_inc_w), .step_dec(step_dec_w),
        .at_max(at_max_w), .at_min(at_min_w), .active(active_w)
    );

    updown_count_controller #(
        .WIDTH(4), .MAX_VALUE(MAXV), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .WRAP(0)
    ) dut_s (
        .reset(reset), .clock(clock), .inc_level(inc_level), .dec_level(dec_level),
        .clear(clear), .count(count_s), .step_inc(step_inc_s), .step_dec(step_dec_s),
        .at_max(at_max_s), .at_min(at_min_s), .active(active_s)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_count[0] = 0; m_count[1] = 0;
        m_si[0] = 0; m_si[1] = 0; m_sd[0] = 0; m_sd[1] = 0;
        m_mode = M_IDLE; m_since = 0; m_rep = 0; m_pi = 0; m_pd = 0;
    endtask

    task automatic model_step(input bit i, input bit d, input bit c);
        bit ri, rd, owner, other;
        int dir;
        ri = i && !m_pi;
        rd = d && !m_pd;
        m_pi = i;
        m_pd = d;
        dir = 0;
        for (int v = 0; v < 2; v++) begin
            m_si[v] = 0;
            m_sd[v] = 0;
        end
        if (c) begin
            m_count[0] = 0; m_count[1] = 0;
            m_mode = (i || d) ? M_LOCK : M_IDLE;
            m_since = 0; m_rep = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (ri && rd) m_mode = M_LOCK;
                else if (ri || rd) begin
                    m_mode = ri ? M_INC : M_DEC;
                    dir = ri ? 1 : -1;
                    m_since = 0;
                    m_rep = 0;
                end
            end
            M_INC, M_DEC: begin
                owner = (m_mode == M_INC) ? i : d;
                other = (m_mode == M_INC) ? d : i;
                if (!owner) m_mode = other ? M_LOCK : M_IDLE;
                else begin
                    m_since++;
                    if (m_since == (m_rep ? REPEAT : HOLD)) begin
                        dir = (m_mode == M_INC) ? 1 : -1;
                        m_since = 0;
                        m_rep = 1;
                    end
                end
            end
            default: if (!i && !d) m_mode = M_IDLE;
        endcase
        for (int v = 0; v < 2; v++) begin
            if (dir > 0) begin
                if (m_count[v] < MAXV) begin m_count[v]++; m_si[v] = 1; end
                else if (v == 0) begin m_count[v] = 0; m_si[v] = 1; end
            end else if (dir < 0) begin
                if (m_count[v] > 0) begin m_count[v]--; m_sd[v] = 1; end
                else if (v == 0) begin m_count[v] = MAXV; m_sd[v] = 1; end
            end
        end
    endtask

    function automatic logic [15:0] model_vec(input int v);
        return 16'({4'(m_count[v]), m_si[v], m_sd[v], (m_count[v] == MAXV),
                    (m_count[v] == 0), (m_mode != M_IDLE)});
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_wrap"}, 16'({count_w, step_inc_w, step_dec_w, at_max_w, at_min_w, active_w}),
              model_vec(0));
        check({tag, "_sat"}, 16'({count_s, step_inc_s, step_dec_s, at_max_s, at_min_s, active_s}),
              model_vec(1));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step(inc_level, dec_level, clear);
        #1;
        check_model("model");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async_reset");
        reset = 1'b0;
    endtask

    task automatic tap_inc();
        inc_level = 1'b1; tick();
        inc_level = 1'b0; tick();
    endtask

    typedef struct {
        logic       inc, dec, clr;
        logic [3:0] cw;
        logic       siw, sdw;
        logic [3:0] cs;
        logic       sis, sds, act;
    } row_t;

    row_t rows[11];

    initial begin
        logic [31:0] mask;
        logic        any_dec;

        rows[0]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1};
        rows[1]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1};
        rows[2]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1};
        rows[3]  = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        rows[4]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
        rows[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        rows[6]  = '{1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
        rows[7]  = '{1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        rows[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1};
        rows[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        rows[10] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; inc_level = 1'b0; dec_level = 1'b0; clear = 1'b0;
        model_reset();
        tick(); tick();
        check("reset_state", 16'({count_w, step_inc_w, step_dec_w, at_max_w, at_min_w, active_w}),
              16'({4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        reset = 1'b0;

        // Taps, wrap/saturate at zero and wrap at max, then clear.
        for (int r = 0; r < 11; r++) begin
            inc_level = rows[r].inc; dec_level = rows[r].dec; clear = rows[r].clr;
            tick();
            check("table_wrap", 16'({count_w, step_inc_w, step_dec_w, active_w}),
                  16'({rows[r].cw, rows[r].siw, rows[r].sdw, rows[r].act}));
            check("table_sat", 16'({count_s, step_inc_s, step_dec_s, active_s}),
                  16'({rows[r].cs, rows[r].sis, rows[r].sds, rows[r].act}));
        end
        clear = 1'b0;

        // Hold for 20 edges: steps at edges 1, 9, 13, 17.
        pulse_reset();
        inc_level = 1'b1; mask = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (step_inc_w) mask[k] = 1'b1;
        end
        inc_level = 1'b0; tick();
        if (step_inc_w) mask[21] = 1'b1;
        check("hold_repeat_pulses", 16'(mask >> 1), 16'(32'h0002_2202 >> 1));
        check("hold_repeat_count", 16'(count_w), 16'd4);

        // Saturate at max versus wrap at max.
        pulse_reset();
        for (int k = 0; k < 9; k++) tap_inc();
        check("preload_max", 16'({count_w, count_s}), 16'({4'd9, 4'd9}));
        inc_level = 1'b1; tick();
        check("max_wrap", 16'({count_w, step_inc_w}), 16'({4'd0, 1'b1}));
        check("max_sat", 16'({count_s, step_inc_s, at_max_s}), 16'({4'd9, 1'b0, 1'b1}));
        inc_level = 1'b0; tick();

        // Simultaneous press at 5.
        pulse_reset();
        for (int k = 0; k < 5; k++) tap_inc();
        inc_level = 1'b1; dec_level = 1'b1; tick();
        check("both_rise", 16'({count_w, step_inc_w, step_dec_w, active_w}), 16'({4'd5, 1'b0, 1'b0, 1'b1}));
        inc_level = 1'b0; tick();
        check("lock_inc_released", 16'({count_w, active_w}), 16'({4'd5, 1'b1}));
        dec_level = 1'b0; tick();
        check("lock_exit", 16'({count_w, active_w}), 16'({4'd5, 1'b0}));

        // Contention: dec pressed while inc owns the count.
        pulse_reset();
        inc_level = 1'b1; mask = '0; any_dec = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) dec_level = 1'b1;
            tick();
            if (step_inc_w) mask[k] = 1'b1;
            if (step_dec_w) any_dec = 1'b1;
        end
        check("contention_pulses", 16'({mask[15:0]}), 16'h2202);
        inc_level = 1'b0; tick();
        check("contention_lock", 16'({count_w, active_w}), 16'({4'd3, 1'b1}));
        for (int k = 0; k < 6; k++) begin
            tick();
            if (step_dec_w) any_dec = 1'b1;
        end
        check("contention_no_dec", 16'({any_dec, count_w}), 16'({1'b0, 4'd3}));
        dec_level = 1'b0; tick();
        check("contention_idle", 16'(active_w), 16'd0);

        // Async reset during auto-repeat at 7.
        pulse_reset();
        inc_level = 1'b1;
        for (int k = 0; k < 29; k++) tick();
        check("pre_reset_count", 16'({count_w, active_w}), 16'({4'd7, 1'b1}));
        pulse_reset();
        check("mid_rep_reset", 16'({count_w, step_inc_w, at_min_w, active_w}), 16'({4'd0, 1'b0, 1'b1, 1'b0}));
        inc_level = 1'b0; tick();

        // Clear while inc held at 6, on the edge a repeat step was due.
        pulse_reset();
        inc_level = 1'b1;
        for (int k = 0; k < 28; k++) tick();
        check("pre_clear_count", 16'(count_w), 16'd6);
        clear = 1'b1; tick();
        check("clear_held", 16'({count_w, step_inc_w, active_w}), 16'({4'd0, 1'b0, 1'b1}));
        clear = 1'b0; inc_level = 1'b0; tick();
        check("clear_release", 16'(active_w), 16'd0);

        // Randomized levels with long holds, occasional clear and async reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) inc_level = ~inc_level;
            if ($urandom_range(19) == 0) dec_level = ~dec_level;
            clear = ($urandom_range(149) == 0);
            if ($urandom_range(599) == 0) pulse_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
